// File: rtl/ldpc_pkg.sv
// Shared LDPC definitions: node state encodings, lane slicing and
// accumulator guard width used by both variable and check nodes.

`ifndef LDPC_LANE
`define LDPC_LANE(k, w) ((k)*(w)) +: (w)
`endif

package ldpc_pkg;

  localparam int WEIGHT_DEFAULT       = 3;
  localparam int FLOAT_LENGTH_DEFAULT = 15;
  // Extra accumulator bits above the message width; 2^guard must exceed weight+1.
  localparam int SAT_GUARD_BITS       = 3;

  typedef enum logic [2:0] {
    VN_IDLE            = 3'd0,
    VN_WAIT_CHECK      = 3'd1,
    VN_ACCUMULATE      = 3'd2,
    VN_DECIDE          = 3'd3,
    VN_UPDATE_VARIABLE = 3'd4
  } vn_state_t;

  typedef enum logic [1:0] {
    CN_IDLE    = 2'd0,
    CN_COLLECT = 2'd1,
    CN_COMPUTE = 2'd2,
    CN_EMIT    = 2'd3
  } cn_state_t;

endpackage

// File: rtl/ldpc_sat.sv
// Symmetric saturation from a wide accumulator to message width.
// The most negative message code is never produced, so the check side
// can always negate a message safely.

module ldpc_sat #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 15
) (
  input  logic [IN_W-1:0]  sat_in,
  output logic [OUT_W-1:0] sat_out
);

  localparam logic signed [IN_W-1:0] POS_LIMIT = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] NEG_LIMIT = -POS_LIMIT;

  logic signed [IN_W-1:0] in_s;

  assign in_s = sat_in;

  // Clip to +/-(2^(OUT_W-1)-1), pass through otherwise.
  always_comb begin
    if (in_s > POS_LIMIT) begin
      sat_out = POS_LIMIT[OUT_W-1:0];
    end else if (in_s < NEG_LIMIT) begin
      sat_out = NEG_LIMIT[OUT_W-1:0];
    end else begin
      sat_out = in_s[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/variable_node.sv
// Min-sum LDPC variable node. Holds a channel LLR, collects one message per
// connected check node, forms the hard decision from the total and returns
// extrinsic messages (total minus each lane's own input) lane by lane.

module variable_node
  import ldpc_pkg::*;
#(
  parameter int weight       = WEIGHT_DEFAULT,
  parameter int float_length = FLOAT_LENGTH_DEFAULT,
  parameter int sum_length   = float_length + SAT_GUARD_BITS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             channel_load,
  input  logic [float_length-1:0]          channel_value,
  input  logic                             halt,
  input  logic [weight*float_length-1:0]   check_value_input,
  input  logic [weight-1:0]                check_enable_input,
  output logic [weight*float_length-1:0]   variable_value_output,
  output logic [weight-1:0]                variable_enable_output,
  output logic                             decision_bit,
  output logic                             decision_valid
);

  localparam int              JW     = (weight > 1) ? $clog2(weight) : 1;
  localparam logic [JW-1:0]   J_LAST = JW'(weight - 1);
  localparam logic [JW-1:0]   J_ZERO = JW'(0);
  localparam logic [JW-1:0]   J_ONE  = JW'(1);
  localparam int              EXT    = sum_length - float_length;

  vn_state_t                       state_q, state_d;
  logic [float_length-1:0]         channel_q, channel_d;
  logic [weight*float_length-1:0]  check_q, check_d;
  logic [sum_length-1:0]           acc_q, acc_d;
  logic [JW-1:0]                   j_q, j_d;
  logic [weight-1:0]               ack_seen_q, ack_seen_d;
  logic [weight-1:0]               captured_q, captured_d;
  logic [weight*float_length-1:0]  var_value_q, var_value_d;
  logic [weight-1:0]               var_en_q, var_en_d;
  logic                            decision_bit_q, decision_bit_d;
  logic                            decision_valid_q, decision_valid_d;

  logic [float_length-1:0]         acc_lane_s;
  logic [float_length-1:0]         upd_lane_s;
  logic [float_length-1:0]         sat_out_s;
  logic [sum_length-1:0]           acc_sum_s;
  logic [sum_length-1:0]           sat_in_s;
  int                              upd_idx_s;

  function automatic logic [sum_length-1:0] sext(input logic [float_length-1:0] v);
    return {{EXT{v[float_length-1]}}, v};
  endfunction

  // Lane selection for the running sum and for the extrinsic subtraction.
  // Outputs are computed one cycle ahead so lane j is visible during
  // UPDATE_VARIABLE cycle j (lane 0 is prepared while in DECIDE).
  always_comb begin
    acc_lane_s = check_q[`LDPC_LANE(int'(j_q), float_length)];
    if ((state_q == VN_UPDATE_VARIABLE) && (j_q != J_LAST)) begin
      upd_idx_s = int'(j_q) + 1;
    end else begin
      upd_idx_s = 0;
    end
    upd_lane_s = check_q[`LDPC_LANE(upd_idx_s, float_length)];
    acc_sum_s  = acc_q + sext(acc_lane_s);
    sat_in_s   = acc_q - sext(upd_lane_s);
  end

  ldpc_sat #(
    .IN_W  (sum_length),
    .OUT_W (float_length)
  ) u_sat (
    .sat_in  (sat_in_s),
    .sat_out (sat_out_s)
  );

  // Next-state logic: load restarts from anywhere, halt parks in IDLE.
  always_comb begin
    state_d          = state_q;
    channel_d        = channel_q;
    check_d          = check_q;
    acc_d            = acc_q;
    j_d              = j_q;
    ack_seen_d       = ack_seen_q;
    captured_d       = captured_q;
    var_value_d      = var_value_q;
    var_en_d         = var_en_q;
    decision_bit_d   = decision_bit_q;
    decision_valid_d = 1'b0;

    if (channel_load) begin
      channel_d = channel_value;
      for (int k = 0; k < weight; k++) begin
        var_value_d[`LDPC_LANE(k, float_length)] = channel_value;
      end
      var_en_d   = {weight{1'b1}};
      ack_seen_d = {weight{1'b0}};
      captured_d = {weight{1'b0}};
      j_d        = J_ZERO;
      state_d    = VN_WAIT_CHECK;
    end else if (halt) begin
      var_en_d = {weight{1'b0}};
      state_d  = VN_IDLE;
    end else begin
      case (state_q)
        VN_IDLE: begin
          state_d = VN_IDLE;
        end
        VN_WAIT_CHECK: begin
          // A lane is accepted only after it has been seen low, then high.
          for (int k = 0; k < weight; k++) begin
            if (!check_enable_input[k]) begin
              ack_seen_d[k] = 1'b1;
              var_en_d[k]   = 1'b0;
            end else if (ack_seen_q[k] && !captured_q[k]) begin
              check_d[`LDPC_LANE(k, float_length)] = check_value_input[`LDPC_LANE(k, float_length)];
              captured_d[k] = 1'b1;
            end else begin
              captured_d[k] = captured_q[k];
            end
          end
          if (&captured_q) begin
            acc_d   = sext(channel_q);
            j_d     = J_ZERO;
            state_d = VN_ACCUMULATE;
          end else begin
            state_d = VN_WAIT_CHECK;
          end
        end
        VN_ACCUMULATE: begin
          acc_d = acc_sum_s;
          if (j_q == J_LAST) begin
            decision_bit_d   = acc_sum_s[sum_length-1];
            decision_valid_d = 1'b1;
            j_d              = J_ZERO;
            state_d          = VN_DECIDE;
          end else begin
            j_d     = j_q + J_ONE;
            state_d = VN_ACCUMULATE;
          end
        end
        VN_DECIDE: begin
          var_value_d[`LDPC_LANE(0, float_length)] = sat_out_s;
          var_en_d[0] = 1'b1;
          j_d         = J_ZERO;
          state_d     = VN_UPDATE_VARIABLE;
        end
        VN_UPDATE_VARIABLE: begin
          if (j_q == J_LAST) begin
            ack_seen_d = {weight{1'b0}};
            captured_d = {weight{1'b0}};
            j_d        = J_ZERO;
            state_d    = VN_WAIT_CHECK;
          end else begin
            var_value_d[`LDPC_LANE(upd_idx_s, float_length)] = sat_out_s;
            var_en_d[upd_idx_s] = 1'b1;
            j_d     = j_q + J_ONE;
            state_d = VN_UPDATE_VARIABLE;
          end
        end
        default: begin
          state_d = VN_IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= VN_IDLE;
      channel_q        <= {float_length{1'b0}};
      check_q          <= {(weight*float_length){1'b0}};
      acc_q            <= {sum_length{1'b0}};
      j_q              <= J_ZERO;
      ack_seen_q       <= {weight{1'b0}};
      captured_q       <= {weight{1'b0}};
      var_value_q      <= {(weight*float_length){1'b0}};
      var_en_q         <= {weight{1'b0}};
      decision_bit_q   <= 1'b0;
      decision_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      channel_q        <= channel_d;
      check_q          <= check_d;
      acc_q            <= acc_d;
      j_q              <= j_d;
      ack_seen_q       <= ack_seen_d;
      captured_q       <= captured_d;
      var_value_q      <= var_value_d;
      var_en_q         <= var_en_d;
      decision_bit_q   <= decision_bit_d;
      decision_valid_q <= decision_valid_d;
    end
  end

  assign variable_value_output  = var_value_q;
  assign variable_enable_output = var_en_q;
  assign decision_bit           = decision_bit_q;
  assign decision_valid         = decision_valid_q;

endmodule
